lcd_ctrl: RTL and testbench

- Memory-mapped HD44780-style character-LCD controller.
- Sits behind the load/store unit: the LSU decodes a store to the LCD address and hands the store data to this block as a one-word command.
- The block runs the power-up init sequence, then drives the LCD pins with correctly timed EN strobes and post-command waits.
- It flow-controls the LSU side with valid/ready.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_ctrl_if.sv | 12 +
 rtl/lcd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character-LCD controller.
// Holds the FSM state encoding, the power-up init ROM and the command field layout.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    INIT     = 3'd1,
    IDLE     = 3'd2,
    SETUP    = 3'd3,
    PULSE    = 3'd4,
    HOLD     = 3'd5,
    WAIT     = 3'd6
  } lcd_state_t;

  localparam int INIT_LEN     = 4;
  localparam int CMD_RS_BIT   = 8;
  localparam int CMD_DATA_MSB = 7;

  // 8-bit bus / 2 lines, display on, clear, entry mode increment
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Command handshake between the LSU (master) and the LCD controller (slave).
// One 9-bit word per transfer: bit 8 is RS, bits 7:0 are the byte.
interface lcd_ctrl_if;

  logic                          valid;
  logic [lcd_pkg::CMD_RS_BIT:0]  cmd;
  logic                          ready;

  modport master (output valid, output cmd, input ready);
  modport slave  (input valid, input cmd, output ready);

endinterface

// File: rtl/lcd_ctrl.sv
// Character-LCD controller: power-up init, then timed EN strobes for LSU commands.
// One shared down-counter times every state; it is loaded with N-1 on entry.
//
// state    | meaning
// PWR_WAIT | LCD powered, waiting out the power-up delay
// INIT     | load the next init ROM entry onto RS/DATA
// IDLE     | init complete, ready for a command
// SETUP    | RS/DATA stable, EN low
// PULSE    | EN high
// HOLD     | EN low, RS/DATA still held
// WAIT     | command execution time on the LCD side
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 12,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  lcd_ctrl_if.slave        cmd_bus,
  output logic             o_init_done,
  output logic [7:0]       o_lcd_data,
  output logic             o_lcd_rs,
  output logic             o_lcd_rw,
  output logic             o_lcd_en,
  output logic             o_lcd_on
);

  localparam int T_MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int T_MAX_B = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
  localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam int IDX_W   = $clog2(INIT_LEN);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  lcd_state_t state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  idx_t       idx, idx_nxt;
  logic       init_done, init_done_nxt;
  logic       lcd_on, lcd_on_nxt;
  logic [7:0] data, data_nxt;
  logic       rs, rs_nxt;
  logic       ready;

  assign ready = (state == IDLE) && init_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= '0;
      init_done <= 1'b0;
      lcd_on    <= 1'b0;
      data      <= 8'h00;
      rs        <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      init_done <= init_done_nxt;
      lcd_on    <= lcd_on_nxt;
      data      <= data_nxt;
      rs        <= rs_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    init_done_nxt = init_done;
    lcd_on_nxt    = 1'b1;
    data_nxt      = data;
    rs_nxt        = rs;
    case (state)
      PWR_WAIT: begin
        // lcd_on still low means this is the first edge after reset: start the delay
        if (!lcd_on) begin
          cnt_nxt = cnt_t'(T_POWERUP - 1);
        end else if (cnt == '0) begin
          state_nxt = INIT;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      INIT: begin
        data_nxt  = INIT_ROM[idx];
        rs_nxt    = 1'b0;
        state_nxt = SETUP;
        cnt_nxt   = cnt_t'(T_SETUP - 1);
      end
      IDLE: begin
        if (cmd_bus.valid && ready) begin
          rs_nxt    = cmd_bus.cmd[CMD_RS_BIT];
          data_nxt  = cmd_bus.cmd[CMD_DATA_MSB:0];
          state_nxt = SETUP;
          cnt_nxt   = cnt_t'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = cnt_t'(T_PULSE - 1);
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = cnt_t'(T_HOLD - 1);
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = WAIT;
          cnt_nxt   = is_long_cmd(rs, data) ? cnt_t'(T_CLEAR - 1) : cnt_t'(T_EXEC - 1);
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          if (init_done) begin
            state_nxt = IDLE;
          end else if (idx == idx_t'(INIT_LEN - 1)) begin
            init_done_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            idx_nxt   = idx + idx_t'(1);
            state_nxt = INIT;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      default: begin
        state_nxt = PWR_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign cmd_bus.ready = ready;
  assign o_init_done   = init_done;
  assign o_lcd_data    = data;
  assign o_lcd_rs      = rs;
  assign o_lcd_rw      = 1'b0;
  assign o_lcd_en      = (state == PULSE);
  assign o_lcd_on      = lcd_on;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with short timing parameters.
// Expected timing comes from a cycle-arithmetic model of the strobe/wait rules.
`timescale 1ns/1ps
module tb_lcd_ctrl;

  localparam int TP  = 20;
  localparam int TS  = 1;
  localparam int TPU = 3;
  localparam int TH  = 1;
  localparam int TE  = 5;
  localparam int TC  = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .T_POWERUP(TP), .T_SETUP(TS), .T_PULSE(TPU),
    .T_HOLD(TH), .T_EXEC(TE), .T_CLEAR(TC)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .cmd_bus    (bus),
    .o_init_done(init_done),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on)
  );

  always #5 clk = ~clk;

  // cyc == e right after rising edge e, counting edge 0 as the first one out of reset
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int rw_high = 0;
  always @(negedge clk) if (lcd_rw !== 1'b0) rw_high <= rw_high + 1;

  logic [7:0] init_exp [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  int         ob_rise [$];
  int         ob_fall [$];
  logic [8:0] ob_val  [$];

  // Reference: clear/home instructions wait TC, everything else TE.
  function automatic int wait_len(input logic [8:0] c);
    if (c[8] == 1'b0 && (c[7:0] == 8'h01 || c[7:0] == 8'h02 || c[7:0] == 8'h03)) return TC;
    return TE;
  endfunction

  task automatic watch_init(output int done_cyc, output bit early_ready, output bit timeout);
    bit prev_en;
    int n;
    ob_rise.delete(); ob_fall.delete(); ob_val.delete();
    prev_en = lcd_en; early_ready = 0; timeout = 0; done_cyc = -1; n = 0;
    while (!init_done && n < 300) begin
      @(posedge clk); #1; n++;
      if (lcd_en && !prev_en) begin
        ob_rise.push_back(cyc);
        ob_val.push_back({lcd_rs, lcd_data});
      end
      if (!lcd_en && prev_en) ob_fall.push_back(cyc);
      if (bus.ready && !init_done) early_ready = 1;
      prev_en = lcd_en;
    end
    if (init_done) done_cyc = cyc;
    else           timeout = 1;
  endtask

  task automatic send(input logic [8:0] c, input int gap, output int k, output int rise,
                      output int fall, output int rdy, output int pulses, output bit stable,
                      output bit to);
    int n;
    bit prev_en;
    k = -1; rise = -1; fall = -1; rdy = -1; pulses = 0; stable = 1; to = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.cmd = c; bus.valid = 1'b1;
    n = 0;
    while (!bus.ready && n < 400) begin @(posedge clk); #1; n++; end
    if (!bus.ready) begin
      to = 1; bus.valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    k = cyc; bus.valid = 1'b0; bus.cmd = 9'($urandom);
    prev_en = 1'b0;
    n = 0;
    while (n < 400) begin
      if ({lcd_rs, lcd_data} !== c) stable = 0;
      if (lcd_en && !prev_en) begin
        pulses++;
        if (rise < 0) rise = cyc;
      end
      if (!lcd_en && prev_en && fall < 0) fall = cyc;
      prev_en = lcd_en;
      if (bus.ready) begin
        rdy = cyc;
        break;
      end
      @(posedge clk); #1; n++;
    end
    if (rdy < 0) to = 1;
  endtask

  task automatic test_reset();
    bus.valid = 1'b1; bus.cmd = 9'h1AA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, bus.ready, init_done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got on=%b en=%b rs=%b rw=%b data=%h rdy=%b done=%b want all 0",
               lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, bus.ready, init_done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lcd_on !== 1'b1 || lcd_en !== 1'b0 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL lcd_on_cycle0 got on=%b en=%b rdy=%b want on=1 en=0 rdy=0",
               lcd_on, lcd_en, bus.ready);
    end
  endtask

  task automatic test_init(input string tag);
    int d, k, r, exp_done;
    bit er, to;
    int exp_rise [4];
    int exp_fall [4];
    watch_init(d, er, to);
    k = TP + 1;
    for (int i = 0; i < 4; i++) begin
      exp_rise[i] = k + TS;
      exp_fall[i] = k + TS + TPU;
      r = exp_fall[i] + TH + wait_len({1'b0, init_exp[i]});
      k = r + 1;
    end
    exp_done = r;
    checks++;
    if (to || d !== exp_done) begin
      errors++;
      $display("FAIL %s_done_cycle got %0d (timeout=%0b) want %0d", tag, d, to, exp_done);
    end
    checks++;
    if (er || bus.ready !== init_done) begin
      errors++;
      $display("FAIL %s_ready got early=%0b rdy=%b done=%b want early=0 rdy=done",
               tag, er, bus.ready, init_done);
    end
    checks++;
    if (ob_rise.size() != 4 || ob_fall.size() != 4) begin
      errors++;
      $display("FAIL %s_pulse_count got rises=%0d falls=%0d want 4", tag, ob_rise.size(),
               ob_fall.size());
    end
    for (int i = 0; i < 4 && i < ob_rise.size() && i < ob_fall.size(); i++) begin
      checks++;
      if (ob_rise[i] !== exp_rise[i] || ob_fall[i] !== exp_fall[i] ||
          ob_val[i] !== {1'b0, init_exp[i]}) begin
        errors++;
        $display("FAIL %s_entry%0d got rise=%0d fall=%0d val=%h want rise=%0d fall=%0d val=%h",
                 tag, i, ob_rise[i], ob_fall[i], ob_val[i], exp_rise[i], exp_fall[i],
                 {1'b0, init_exp[i]});
      end
    end
    checks++;
    if (rw_high != 0) begin
      errors++;
      $display("FAIL %s_rw got %0d cycles with rw!=0 want 0", tag, rw_high);
    end
  endtask

  // Valid has been held since reset; it must be taken on the first ready edge only.
  task automatic test_valid_early();
    int k, n;
    k = cyc + 1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    checks++;
    if (cyc !== k || bus.ready !== 1'b0 || {lcd_rs, lcd_data} !== 9'h1AA) begin
      errors++;
      $display("FAIL early_valid_accept got cyc=%0d rdy=%b val=%h want cyc=%0d rdy=0 val=1aa",
               cyc, bus.ready, {lcd_rs, lcd_data}, k);
    end
    n = 0;
    while (!bus.ready && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (!bus.ready || cyc !== k + TS + TPU + TH + TE) begin
      errors++;
      $display("FAIL early_valid_ready got cyc=%0d rdy=%b want cyc=%0d", cyc, bus.ready,
               k + TS + TPU + TH + TE);
    end
  endtask

  task automatic test_data_write();
    int k, rise, fall, rdy, pulses;
    bit stable, to;
    send(9'h141, 0, k, rise, fall, rdy, pulses, stable, to);
    checks++;
    if (to || rise !== k + TS || fall !== k + TS + TPU || pulses !== 1) begin
      errors++;
      $display("FAIL data_strobe got rise=%0d fall=%0d pulses=%0d to=%0b want rise=%0d fall=%0d pulses=1",
               rise, fall, pulses, to, k + TS, k + TS + TPU);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL data_stable got unstable rs/data want 141 held");
    end
    checks++;
    if (rdy !== k + 10) begin
      errors++;
      $display("FAIL data_ready got %0d want %0d", rdy, k + 10);
    end
  endtask

  task automatic test_long();
    logic [8:0] cmds [3] = '{9'h001, 9'h004, 9'h003};
    int         lat  [3] = '{15, 10, 15};
    int k, rise, fall, rdy, pulses;
    bit stable, to;
    for (int i = 0; i < 3; i++) begin
      send(cmds[i], 1, k, rise, fall, rdy, pulses, stable, to);
      checks++;
      if (to || rdy - k !== lat[i]) begin
        errors++;
        $display("FAIL long_cmd_%h got latency %0d (to=%0b) want %0d", cmds[i], rdy - k, to,
                 lat[i]);
      end
    end
  endtask

  task automatic test_flow();
    int n, k1, r, k2, pulses, rdy2;
    bit bad_data, prev_en;
    n = 0;
    while (!bus.ready && n < 100) begin @(posedge clk); #1; n++; end
    bus.cmd = 9'h130; bus.valid = 1'b1;
    @(posedge clk); #1;
    k1 = cyc;
    bus.cmd = 9'h142;
    r = -1; k2 = -1; bad_data = 0; n = 0;
    while (n < 100) begin
      if (bus.ready) begin
        r = cyc;
        @(posedge clk); #1;
        k2 = cyc; bus.valid = 1'b0;
        break;
      end
      if ({lcd_rs, lcd_data} !== 9'h130) bad_data = 1;
      @(posedge clk); #1; n++;
    end
    bus.valid = 1'b0;
    checks++;
    if (r !== k1 + TS + TPU + TH + TE || k2 !== r + 1) begin
      errors++;
      $display("FAIL flow_first_ready got ready=%0d accept=%0d want ready=%0d accept=%0d",
               r, k2, k1 + TS + TPU + TH + TE, k1 + TS + TPU + TH + TE + 1);
    end
    checks++;
    if (bad_data) begin
      errors++;
      $display("FAIL flow_data_early got data changed before accept want 130 held");
    end
    checks++;
    if (bus.ready !== 1'b0 || {lcd_rs, lcd_data} !== 9'h142) begin
      errors++;
      $display("FAIL flow_accept got rdy=%b val=%h want rdy=0 val=142", bus.ready,
               {lcd_rs, lcd_data});
    end
    pulses = 0; rdy2 = -1; prev_en = 1'b0; n = 0;
    while (n < 30) begin
      if (lcd_en && !prev_en) pulses++;
      prev_en = lcd_en;
      if (bus.ready && rdy2 < 0) rdy2 = cyc;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (pulses !== 1 || rdy2 !== k2 + TS + TPU + TH + TE) begin
      errors++;
      $display("FAIL flow_once got pulses=%0d ready=%0d want pulses=1 ready=%0d", pulses, rdy2,
               k2 + TS + TPU + TH + TE);
    end
  endtask

  task automatic test_random();
    logic [8:0] c;
    int k, rise, fall, rdy, pulses, gap;
    bit stable, to;
    for (int i = 0; i < 20; i++) begin
      c[8] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) c[7:0] = 8'($urandom);
      else                           c[7:0] = 8'($urandom_range(0, 4));
      gap = $urandom_range(0, 3);
      send(c, gap, k, rise, fall, rdy, pulses, stable, to);
      checks++;
      if (to || rdy - k !== TS + TPU + TH + wait_len(c)) begin
        errors++;
        $display("FAIL rand%0d_ready cmd=%h got latency %0d (to=%0b) want %0d", i, c, rdy - k,
                 to, TS + TPU + TH + wait_len(c));
      end
      checks++;
      if (rise - k !== TS || fall - k !== TS + TPU || pulses !== 1 || !stable) begin
        errors++;
        $display("FAIL rand%0d_strobe cmd=%h got rise=+%0d fall=+%0d pulses=%0d stable=%0b want +%0d +%0d 1 1",
                 i, c, rise - k, fall - k, pulses, stable, TS, TS + TPU);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin @(posedge clk); #1; n++; end
    bus.cmd = 9'h155; bus.valid = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pulse got en=%b want 1 before reset", lcd_en);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, bus.ready, init_done} !== 14'd0) begin
      errors++;
      $display("FAIL midreset_outputs got on=%b en=%b rs=%b data=%h rdy=%b done=%b want all 0",
               lcd_on, lcd_en, lcd_rs, lcd_data, bus.ready, init_done);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lcd_on !== 1'b1 || cyc !== 0) begin
      errors++;
      $display("FAIL midreset_restart got on=%b cyc=%0d want on=1 cyc=0", lcd_on, cyc);
    end
    test_init("reinit");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid = 1'b0;
    bus.cmd   = 9'h000;
    test_reset();
    test_init("init");
    test_valid_early();
    test_data_write();
    test_long();
    test_flow();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
